// File: rtl/regfile.sv
// Operand register file for the mcpu pipeline: two combinational read ports with
// write bypass, one writeback port, and a per-register pending-writer scoreboard.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re0,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    output logic              busy0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy1,
    input  logic              iss_we,
    input  logic [ADDR_W-1:0] iss_waddr,
    output logic              iss_full,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              wb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] reg_q [NREG];
    logic [DATA_W-1:0] reg_d [NREG];
    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic              wb_err_q;
    logic              wb_err_d;
    logic              iss_full_raw;

    // A retire to the same register in this cycle frees a slot for the new issue.
    assign iss_full_raw = iss_we && (iss_waddr != '0) && (cnt_q[iss_waddr] == CNT_MAX)
                          && !(we && (waddr == iss_waddr));
    assign iss_full     = !rst && iss_full_raw;

    assign wb_err_d = wb_err_q || (we && (waddr != '0) && (cnt_q[waddr] == '0));
    assign wb_err   = wb_err_q;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign reg_d[gi] = '0;
                assign cnt_d[gi] = '0;
            end else begin : g_gpr
                logic inc;
                logic dec;
                assign inc = iss_we && (iss_waddr == ADDR_W'(gi)) && !iss_full_raw;
                assign dec = we && (waddr == ADDR_W'(gi)) && (cnt_q[gi] != '0);
                assign cnt_d[gi] = (inc && !dec) ? cnt_q[gi] + CNT_ONE :
                                   (dec && !inc) ? cnt_q[gi] - CNT_ONE : cnt_q[gi];
                assign reg_d[gi] = (we && (waddr == ADDR_W'(gi))) ? wdata : reg_q[gi];
            end
        end
    endgenerate

    // Both read ports share identical logic; map them onto small arrays.
    logic              re_v    [2];
    logic [ADDR_W-1:0] raddr_v [2];
    logic [DATA_W-1:0] rdata_v [2];
    logic              busy_v  [2];

    assign re_v[0]    = re0;
    assign re_v[1]    = re1;
    assign raddr_v[0] = raddr0;
    assign raddr_v[1] = raddr1;
    assign rdata0     = rdata_v[0];
    assign rdata1     = rdata_v[1];
    assign busy0      = busy_v[0];
    assign busy1      = busy_v[1];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic active;
            logic hit_wb;
            assign active = !rst && re_v[gi] && (raddr_v[gi] != '0);
            assign hit_wb = we && (waddr == raddr_v[gi]);
            assign rdata_v[gi] = !active ? '0 : (hit_wb ? wdata : reg_q[raddr_v[gi]]);
            // Retiring the last pending writer makes the operand ready this cycle.
            assign busy_v[gi]  = active && (cnt_q[raddr_v[gi]] != '0)
                                 && !(hit_wb && (cnt_q[raddr_v[gi]] == CNT_ONE));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= reg_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            wb_err_q <= wb_err_d;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: a behavioural register/scoreboard model checked every
// cycle, plus hand-computed literal expectations along the directed sequence.
module tb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          re0, re1, busy0, busy1;
    logic [AW-1:0] raddr0, raddr1, iss_waddr, waddr;
    logic [DW-1:0] rdata0, rdata1, wdata;
    logic          iss_we, iss_full, we, wb_err;

    regfile #(.DATA_W(DW), .ADDR_W(AW), .NREG(32), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .re0(re0), .raddr0(raddr0), .rdata0(rdata0), .busy0(busy0),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .busy1(busy1),
        .iss_we(iss_we), .iss_waddr(iss_waddr), .iss_full(iss_full),
        .we(we), .waddr(waddr), .wdata(wdata), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [DW-1:0] m_reg [32];
    int            m_cnt [32];
    bit            m_err;
    bit            m_valid = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic e, input logic [AW-1:0] a);
        if (rst || !e || a == 0) return '0;
        if (we && waddr == a) return wdata;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic e, input logic [AW-1:0] a);
        if (rst || !e || a == 0) return 1'b0;
        if (m_cnt[a] == 0) return 1'b0;
        if (we && waddr == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_full();
        if (rst || !iss_we || iss_waddr == 0) return 1'b0;
        if (we && waddr == iss_waddr) return 1'b0;
        return m_cnt[iss_waddr] == MAXC;
    endfunction

    // Compare the DUT against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        #2;
        if (m_valid) begin
            chk("rdata0", rdata0, exp_rd(re0, raddr0));
            chk("rdata1", rdata1, exp_rd(re1, raddr1));
            chk("busy0", {31'd0, busy0}, {31'd0, exp_busy(re0, raddr0)});
            chk("busy1", {31'd0, busy1}, {31'd0, exp_busy(re1, raddr1)});
            chk("iss_full", {31'd0, iss_full}, {31'd0, exp_full()});
            chk("wb_err", {31'd0, wb_err}, {31'd0, m_err});
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = '0;
                m_cnt[i] = 0;
            end
            m_err   = 0;
            m_valid = 1;
        end else if (m_valid) begin
            bit full;
            full = exp_full();
            if (we && waddr != 0) begin
                m_reg[waddr] = wdata;
                if (m_cnt[waddr] > 0) m_cnt[waddr]--;
                else m_err = 1;
            end
            if (iss_we && iss_waddr != 0 && !full) m_cnt[iss_waddr]++;
        end
    end

    task automatic set_in(input logic r, input logic e0, input logic [AW-1:0] a0,
                          input logic e1, input logic [AW-1:0] a1,
                          input logic iw, input logic [AW-1:0] ia,
                          input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        @(negedge clk);
        rst = r; re0 = e0; raddr0 = a0; re1 = e1; raddr1 = a1;
        iss_we = iw; iss_waddr = ia; we = w; waddr = wa; wdata = wd;
        #3;
    endtask

    initial begin
        rst = 1; re0 = 0; raddr0 = 0; re1 = 0; raddr1 = 0;
        iss_we = 0; iss_waddr = 0; we = 0; waddr = 0; wdata = 0;

        set_in(1, 0,0, 0,0, 0,0, 0,0, 0);
        set_in(1, 1,5, 1,6, 1,5, 1,5, 32'hdead);
        chk("rst_rdata0_forced", rdata0, 32'h0);
        chk("rst_full_forced", {31'd0, iss_full}, 32'h0);

        set_in(0, 1,5, 1,0, 0,0, 0,0, 0);
        chk("reset_rdata0", rdata0, 32'h0);
        chk("reset_rdata1", rdata1, 32'h0);
        chk("reset_busy", {30'd0, busy0, busy1}, 32'h0);
        chk("reset_wb_err", {31'd0, wb_err}, 32'h0);

        set_in(0, 0,0, 0,0, 1,3, 0,0, 0);
        set_in(0, 1,3, 1,3, 0,0, 0,0, 0);
        chk("r3_busy_pending", {31'd0, busy0}, 32'h1);
        set_in(0, 1,3, 0,0, 0,0, 1,3, 32'h1234);
        chk("r3_bypass_busy", {31'd0, busy0}, 32'h0);
        chk("r3_bypass_data", rdata0, 32'h1234);
        set_in(0, 1,3, 1,3, 0,0, 0,0, 0);
        chk("r3_stored", rdata0, 32'h1234);
        chk("r3_port1_same", rdata1, 32'h1234);

        set_in(0, 0,0, 0,0, 0,0, 1,0, 32'hffff_ffff);
        set_in(0, 1,0, 0,0, 0,0, 0,0, 0);
        chk("r0_zero", rdata0, 32'h0);
        chk("r0_no_err", {31'd0, wb_err}, 32'h0);

        repeat (3) set_in(0, 0,0, 0,0, 1,7, 0,0, 0);
        chk("model_r7_cnt3", m_cnt[7], 32'd3);
        set_in(0, 0,0, 1,7, 1,7, 0,0, 0);
        chk("r7_full", {31'd0, iss_full}, 32'h1);
        chk("r7_busy", {31'd0, busy1}, 32'h1);
        set_in(0, 1,7, 0,0, 1,7, 1,7, 32'h77);
        chk("r7_full_freed", {31'd0, iss_full}, 32'h0);
        chk("r7_busy_cnt3_wb", {31'd0, busy0}, 32'h1);
        chk("model_r7_still3", m_cnt[7], 32'd3);
        set_in(0, 0,0, 0,0, 1,7, 0,0, 0);
        chk("r7_full_again", {31'd0, iss_full}, 32'h1);
        repeat (2) set_in(0, 1,7, 1,7, 0,0, 1,7, 32'h700);
        set_in(0, 1,7, 0,0, 0,0, 1,7, 32'h701);
        chk("r7_last_retire", {31'd0, busy0}, 32'h0);

        set_in(0, 0,0, 0,0, 0,0, 1,9, 32'ha5);
        chk("r9_err_not_yet", {31'd0, wb_err}, 32'h0);
        set_in(0, 1,9, 0,0, 0,0, 0,0, 0);
        chk("r9_data", rdata0, 32'ha5);
        chk("r9_err_set", {31'd0, wb_err}, 32'h1);
        repeat (3) set_in(0, 0,0, 0,0, 1,2, 1,2, 32'h22);
        chk("err_sticky", {31'd0, wb_err}, 32'h1);

        repeat (2) set_in(0, 0,0, 0,0, 1,4, 0,0, 0);
        set_in(0, 1,4, 1,4, 1,4, 1,4, 32'h44);
        chk("r4_busy_issue_wb", {31'd0, busy0}, 32'h1);
        chk("r4_port1_busy", {31'd0, busy1}, 32'h1);
        chk("model_r4_cnt2", m_cnt[4], 32'd2);
        set_in(1, 1,4, 1,9, 0,0, 0,0, 0);
        chk("midrst_rdata0", rdata0, 32'h0);
        chk("midrst_busy0", {31'd0, busy0}, 32'h0);
        chk("midrst_rdata1", rdata1, 32'h0);
        set_in(0, 1,4, 1,9, 0,0, 0,0, 0);
        chk("post_rst_r4", rdata0, 32'h0);
        chk("post_rst_busy", {31'd0, busy0}, 32'h0);
        chk("post_rst_err", {31'd0, wb_err}, 32'h0);
        set_in(0, 0,0, 0,0, 0,0, 1,4, 32'h4444);
        set_in(0, 1,4, 0,0, 0,0, 0,0, 0);
        chk("stale_wb_err", {31'd0, wb_err}, 32'h1);
        chk("stale_wb_data", rdata0, 32'h4444);

        set_in(0, 0,0, 0,0, 1,5, 1,6, 32'h66);
        set_in(0, 1,5, 1,6, 1,5, 1,5, 32'h55);
        set_in(0, 1,5, 1,5, 0,0, 0,0, 0);
        chk("r5_still_busy", {31'd0, busy1}, 32'h1);
        set_in(0, 0,0, 0,0, 0,0, 0,0, 0);
        set_in(0, 0,0, 0,0, 0,0, 0,0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
